// File: rtl/peripheral_uart_rx_pkg.sv
// Shared definitions for the J1 UART receiver: FSM states, register map,
// STATUS bit positions and the reset divisor calculation.
package peripheral_uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   localparam logic [3:0] ADDR_RXDATA = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h2;
   localparam logic [3:0] ADDR_DIV    = 4'h4;

   localparam int unsigned STAT_RXAV = 0;
   localparam int unsigned STAT_FULL = 1;
   localparam int unsigned STAT_OVR  = 2;
   localparam int unsigned STAT_FERR = 3;

   // Tick divisor for 16x oversampling, truncated.
   function automatic logic [15:0] reset_div(input int unsigned clk_freq,
                                             input int unsigned baud);
      return 16'(clk_freq / (baud * 16));
   endfunction

endpackage

// File: rtl/peripheral_uart_rx_fifo.sv
// Synchronous receive FIFO with combinational head output.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Next pointer/count values; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, written at the tail.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/peripheral_uart_rx.sv
// UART 8N1 receiver peripheral for the J1 SoC: 2-FF synchroniser, 16x tick
// generator, receive FSM, FIFO and cs/rd/wr register interface.
module peripheral_uart_rx #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   input  logic        uart_rx
);

   import peripheral_uart_rx_pkg::*;

   localparam logic [15:0] RST_DIV = reset_div(CLK_FREQ, BAUD);
   localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]  sync_q;
   logic        rx_s;
   logic [15:0] div_q, div_d;
   logic [15:0] tick_cnt_q;
   logic [15:0] reload;
   logic        tick;
   rx_state_e   state_q;
   logic [3:0]  s_q;
   logic [2:0]  b_q;
   logic [7:0]  shreg_q;
   logic        push_q;
   logic [7:0]  byte_q;
   logic        ferr_set_q;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic [15:0] d_out_q, d_out_d;
   logic        rd_en, wr_en, pop, ovr_set;
   logic [7:0]  fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic        fifo_full, fifo_empty;

   assign rx_s    = sync_q[1];
   assign rd_en   = cs && rd;
   assign wr_en   = cs && wr;
   assign pop     = rd_en && (addr == ADDR_RXDATA) && !fifo_empty;
   assign ovr_set = push_q && fifo_full && !pop;
   assign reload  = (div_q == '0) ? '0 : div_q - 16'd1;
   assign tick    = (state_q != ST_IDLE) && (tick_cnt_q == '0);
   assign d_out   = d_out_q;

   // Two-flop synchroniser on the serial input; idles high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= {sync_q[0], uart_rx};
   end

   // Tick counter: parked at reload while idle so ticks are phase-aligned to the start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                         tick_cnt_q <= '0;
      else if (state_q == ST_IDLE || tick_cnt_q == '0) tick_cnt_q <= reload;
      else                                              tick_cnt_q <= tick_cnt_q - 16'd1;
   end

   // Receive FSM with registered push and framing-error pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         b_q        <= '0;
         shreg_q    <= '0;
         push_q     <= 1'b0;
         byte_q     <= '0;
         ferr_set_q <= 1'b0;
      end else begin
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_q <= ST_START;
                  s_q     <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  s_q <= s_q + 4'd1;
                  if (s_q == 4'd7) begin
                     s_q     <= '0;
                     b_q     <= '0;
                     state_q <= rx_s ? ST_IDLE : ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  s_q <= s_q + 4'd1;
                  if (s_q == 4'd15) begin
                     shreg_q <= {rx_s, shreg_q[7:1]};
                     if (b_q == 3'd7) state_q <= ST_STOP;
                     else             b_q     <= b_q + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  s_q <= s_q + 4'd1;
                  if (s_q == 4'd15) begin
                     if (rx_s) begin
                        push_q  <= 1'b1;
                        byte_q  <= shreg_q;
                        state_q <= ST_IDLE;
                     end else begin
                        ferr_set_q <= 1'b1;
                        state_q    <= ST_BREAK;
                     end
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .pop   (pop),
      .wdata (byte_q),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Register writes and sticky flags; a set in the same cycle as a W1C wins.
   always_comb begin
      div_d  = div_q;
      ovr_d  = ovr_q;
      ferr_d = ferr_q;
      if (wr_en && addr == ADDR_DIV) div_d = d_in;
      if (wr_en && addr == ADDR_STATUS && d_in[STAT_OVR])  ovr_d  = 1'b0;
      if (wr_en && addr == ADDR_STATUS && d_in[STAT_FERR]) ferr_d = 1'b0;
      if (ovr_set)    ovr_d  = 1'b1;
      if (ferr_set_q) ferr_d = 1'b1;
   end

   // Read mux feeding the d_out register.
   always_comb begin
      d_out_d = '0;
      case (addr)
         ADDR_RXDATA: if (!fifo_empty) d_out_d = {8'h00, fifo_rdata};
         ADDR_STATUS: begin
            d_out_d[7:4]       = 4'(fifo_count);
            d_out_d[STAT_FERR] = ferr_q;
            d_out_d[STAT_OVR]  = ovr_q;
            d_out_d[STAT_FULL] = fifo_full;
            d_out_d[STAT_RXAV] = !fifo_empty;
         end
         ADDR_DIV:    d_out_d = div_q;
         default:     d_out_d = '0;
      endcase
   end

   // Control/status registers and registered read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= RST_DIV;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         d_out_q <= '0;
      end else begin
         div_q  <= div_d;
         ovr_q  <= ovr_d;
         ferr_q <= ferr_d;
         if (rd_en) d_out_q <= d_out_d;
      end
   end

endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Self-checking bench for peripheral_uart_rx with a queue-based reference model.
module tb_peripheral_uart_rx;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned BITC  = 27 * 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] d_in = '0;
   logic        cs = 1'b0;
   logic [3:0]  addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] d_out;
   logic        uart_rx = 1'b1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [7:0]  mq[$];
   logic        m_ovr = 1'b0;
   logic        m_ferr = 1'b0;
   logic [15:0] v, e;

   peripheral_uart_rx #(
      .CLK_FREQ   (50_000_000),
      .BAUD       (115200),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .d_in    (d_in),
      .cs      (cs),
      .addr    (addr),
      .rd      (rd),
      .wr      (wr),
      .d_out   (d_out),
      .uart_rx (uart_rx)
   );

   always #5 clk = ~clk;

   // Reference model.
   function automatic logic [15:0] m_status();
      logic [3:0] c;
      c = 4'(mq.size());
      return {8'h00, c, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
   endfunction

   task automatic m_rx(input logic [7:0] b);
      if (mq.size() < DEPTH) mq.push_back(b);
      else                   m_ovr = 1'b1;
   endtask

   task automatic m_pop(output logic [15:0] exp);
      if (mq.size() == 0) exp = 16'h0000;
      else                exp = {8'h00, mq.pop_front()};
   endtask

   // Bus and serial drivers, all on the falling edge.
   task automatic bus_read(input logic [3:0] a, output logic [15:0] data);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      data = d_out;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] data);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; d_in = '0;
   endtask

   task automatic hold(input logic lvl, input int unsigned cyc);
      uart_rx = lvl;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int unsigned bitc,
                             input bit stop_ok, input int unsigned low_bits);
      @(negedge clk);
      hold(1'b0, bitc);
      for (int i = 0; i < 8; i++) hold(b[i], bitc);
      if (stop_ok) hold(1'b1, bitc);
      else         hold(1'b0, low_bits * bitc);
      hold(1'b1, 16);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (d_out !== 16'h0000) begin
         errors++; $display("FAIL reset_dout got %h exp %h", d_out, 16'h0000);
      end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL reset_status got %h exp %h", v, e); end
      bus_read(4'h4, v); checks++;
      if (v !== 16'd27) begin errors++; $display("FAIL reset_div got %h exp %h", v, 16'd27); end
      bus_read(4'h0, v); m_pop(e); checks++;
      if (v !== e) begin errors++; $display("FAIL empty_rxdata got %h exp %h", v, e); end
      bus_read(4'h6, v); checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h exp %h", v, 16'h0000); end
   endtask

   task automatic test_two_bytes();
      send_frame(8'h55, BITC, 1'b1, 0); m_rx(8'h55);
      send_frame(8'hA3, BITC, 1'b1, 0); m_rx(8'hA3);
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL two_status got %h exp %h", v, e); end
      for (int i = 0; i < 2; i++) begin
         bus_read(4'h0, v); m_pop(e); checks++;
         if (v !== e) begin errors++; $display("FAIL two_rxdata got %h exp %h", v, e); end
      end
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL two_status_empty got %h exp %h", v, e); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), BITC, 1'b1, 0); m_rx(8'(i));
      end
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL ovr_status got %h exp %h", v, e); end
      for (int i = 0; i < 4; i++) begin
         bus_read(4'h0, v); m_pop(e); checks++;
         if (v !== e) begin errors++; $display("FAIL ovr_rxdata got %h exp %h", v, e); end
      end
      bus_write(4'h2, 16'h0004); m_ovr = 1'b0;
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL ovr_clear got %h exp %h", v, e); end
   endtask

   task automatic test_framing();
      send_frame(8'h3C, BITC, 1'b0, 3); m_ferr = 1'b1;
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL ferr_status got %h exp %h", v, e); end
      send_frame(8'h7E, BITC, 1'b1, 0); m_rx(8'h7E);
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL break_status got %h exp %h", v, e); end
      bus_read(4'h0, v); m_pop(e); checks++;
      if (v !== e) begin errors++; $display("FAIL break_rxdata got %h exp %h", v, e); end
      bus_write(4'h2, 16'h0008); m_ferr = 1'b0;
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL ferr_clear got %h exp %h", v, e); end
   endtask

   task automatic test_glitch_div0();
      @(negedge clk);
      hold(1'b0, 27);
      hold(1'b1, 2 * BITC);
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL glitch_status got %h exp %h", v, e); end
      bus_write(4'h4, 16'h0000);
      bus_read(4'h4, v); checks++;
      if (v !== 16'h0000) begin errors++; $display("FAIL div0_read got %h exp %h", v, 16'h0000); end
      send_frame(8'h81, 16, 1'b1, 0); m_rx(8'h81);
      bus_read(4'h0, v); m_pop(e); checks++;
      if (v !== e) begin errors++; $display("FAIL div0_rxdata got %h exp %h", v, e); end
   endtask

   task automatic test_random();
      int unsigned d, op;
      logic [7:0] b;
      d = $urandom_range(2, 5);
      bus_write(4'h4, 16'(d));
      bus_read(4'h4, v); checks++;
      if (v !== 16'(d)) begin errors++; $display("FAIL rand_div got %h exp %h", v, 16'(d)); end
      for (int n = 0; n < 30; n++) begin
         op = $urandom_range(0, 3);
         if (op < 2) begin
            b = 8'($urandom);
            send_frame(b, d * 16, 1'b1, 0); m_rx(b);
         end else if (op == 2) begin
            bus_read(4'h0, v); m_pop(e); checks++;
            if (v !== e) begin errors++; $display("FAIL rand_rxdata got %h exp %h", v, e); end
         end else begin
            bus_read(4'h2, v); e = m_status(); checks++;
            if (v !== e) begin errors++; $display("FAIL rand_status got %h exp %h", v, e); end
         end
      end
      while (mq.size() != 0) begin
         bus_read(4'h0, v); m_pop(e); checks++;
         if (v !== e) begin errors++; $display("FAIL rand_drain got %h exp %h", v, e); end
      end
      bus_write(4'h2, 16'h000C); m_ovr = 1'b0; m_ferr = 1'b0;
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL rand_final_status got %h exp %h", v, e); end
   endtask

   task automatic test_reset_mid_frame();
      int unsigned d;
      bus_read(4'h4, v);
      d = 32'(v) * 16;
      @(negedge clk);
      hold(1'b0, d);
      hold(1'b0, d);
      hold(1'b1, d);
      hold(1'b0, d / 2);
      rst = 1'b0;
      mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (d_out !== 16'h0000) begin errors++; $display("FAIL midrst_dout got %h exp %h", d_out, 16'h0000); end
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      bus_read(4'h4, v); checks++;
      if (v !== 16'd27) begin errors++; $display("FAIL midrst_div got %h exp %h", v, 16'd27); end
      send_frame(8'h99, BITC, 1'b1, 0); m_rx(8'h99);
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL midrst_status got %h exp %h", v, e); end
      bus_read(4'h0, v); m_pop(e); checks++;
      if (v !== e) begin errors++; $display("FAIL midrst_rxdata got %h exp %h", v, e); end
      bus_read(4'h2, v); e = m_status(); checks++;
      if (v !== e) begin errors++; $display("FAIL midrst_status_empty got %h exp %h", v, e); end
   endtask

   initial begin
      test_reset();
      test_two_bytes();
      test_overflow();
      test_framing();
      test_glitch_div0();
      test_random();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
